// File: rtl/ctrl_tx.sv
// ctrl_tx: master-side RS-485 control-line transmitter.
// Captures one fx-bus command per request/ack handshake, builds a six-byte
// frame (header, command, address high/low, data, XOR checksum) and sends it
// as UART 8N1, LSB first, with the transceiver enable wrapped around it.
module ctrl_tx #(
   parameter int         BAUD_DIV = 434,
   parameter int         DE_LEAD  = 1,
   parameter int         DE_TAIL  = 1,
   parameter logic [7:0] HDR      = 8'hA5
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        cmd_req,
   input  logic        cmd_wr,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_data,
   output logic        cmd_ack,
   output logic        busy,
   output logic        tx_ctrl,
   output logic        de_ctrl
);

   // Baud counter width and the width of the per-state period counter, which
   // counts lead periods, data bits and tail periods.
   localparam int CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int PMAX = (DE_LEAD > DE_TAIL) ? ((DE_LEAD > 8) ? DE_LEAD : 8)
                                             : ((DE_TAIL > 8) ? DE_TAIL : 8);
   localparam int PW   = $clog2(PMAX);

   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_START,
      S_DATA,
      S_STOP,
      S_TAIL
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [PW-1:0]   per_q, per_d;
   logic [2:0]      byte_q, byte_d;
   logic [7:0]      shift_q, shift_d;

   logic [7:0]      cmd_q, ahi_q, alo_q, dat_q, chk_q;
   logic [7:0]      cur_byte;

   logic            tx_q, tx_d;
   logic            de_q, de_d;
   logic            busy_q, busy_d;
   logic            ack_q, ack_d;

   logic            capture;
   logic            tick;
   logic            lead_last;
   logic            tail_last;
   logic            bit_last;
   logic            more_bytes;

   function automatic logic [7:0] frame_chk(input logic [7:0] c,
                                            input logic [7:0] ah,
                                            input logic [7:0] al,
                                            input logic [7:0] d);
      return c ^ ah ^ al ^ d;
   endfunction

   assign capture    = (state_q == S_IDLE) && cmd_req;
   assign tick       = (baud_q == CW'(BAUD_DIV - 1));
   assign lead_last  = (int'(per_q) == DE_LEAD - 1);
   assign tail_last  = (int'(per_q) == DE_TAIL - 1);
   assign bit_last   = (per_q == PW'(7));
   assign more_bytes = (byte_q < 3'd5);

   // Select the frame byte currently being serialised.
   always_comb begin
      cur_byte = HDR;
      case (byte_q)
         3'd0:    cur_byte = HDR;
         3'd1:    cur_byte = cmd_q;
         3'd2:    cur_byte = ahi_q;
         3'd3:    cur_byte = alo_q;
         3'd4:    cur_byte = dat_q;
         3'd5:    cur_byte = chk_q;
         default: cur_byte = HDR;
      endcase
   end

   // FSM state register; reset aborts any frame in progress.
   always_ff @(posedge clk_sys) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: every non-idle state advances only on a bit boundary.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (capture) state_d = (DE_LEAD > 0) ? S_LEAD : S_START;
         end
         S_LEAD: begin
            if (tick && lead_last) state_d = S_START;
         end
         S_START: begin
            if (tick) state_d = S_DATA;
         end
         S_DATA: begin
            if (tick && bit_last) state_d = S_STOP;
         end
         S_STOP: begin
            if (tick) begin
               if (more_bytes)       state_d = S_START;
               else if (DE_TAIL > 0) state_d = S_TAIL;
               else                  state_d = S_IDLE;
            end
         end
         S_TAIL: begin
            if (tick && tail_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Baud, period and byte counters plus the data shift register.
   always_comb begin
      baud_d  = '0;
      per_d   = per_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      if (state_q == S_IDLE) begin
         baud_d = '0;
         per_d  = '0;
         byte_d = '0;
      end else begin
         baud_d = tick ? '0 : baud_q + CW'(1);
         if (tick) begin
            case (state_q)
               S_LEAD:  per_d = lead_last ? '0 : per_q + PW'(1);
               S_TAIL:  per_d = tail_last ? '0 : per_q + PW'(1);
               S_START: begin
                  per_d   = '0;
                  shift_d = cur_byte;
               end
               S_DATA: begin
                  per_d   = bit_last ? '0 : per_q + PW'(1);
                  shift_d = {1'b0, shift_q[7:1]};
               end
               S_STOP: begin
                  per_d = '0;
                  if (more_bytes) byte_d = byte_q + 3'd1;
               end
               default: per_d = per_q;
            endcase
         end
      end
   end

   // Output decode from the next state, so the line and enable are registered.
   always_comb begin
      tx_d   = 1'b1;
      de_d   = (state_d != S_IDLE);
      busy_d = (state_d != S_IDLE);
      ack_d  = capture;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // Control registers: counters and outputs, all cleared by reset.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         baud_q <= '0;
         per_q  <= '0;
         byte_q <= '0;
         tx_q   <= 1'b1;
         de_q   <= 1'b0;
         busy_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         baud_q <= baud_d;
         per_q  <= per_d;
         byte_q <= byte_d;
         tx_q   <= tx_d;
         de_q   <= de_d;
         busy_q <= busy_d;
         ack_q  <= ack_d;
      end
   end

   // Frame payload capture; a read always sends a zero data byte.
   always_ff @(posedge clk_sys) begin
      shift_q <= shift_d;
      if (capture) begin
         cmd_q <= cmd_wr ? CMD_WR : CMD_RD;
         ahi_q <= cmd_addr[15:8];
         alo_q <= cmd_addr[7:0];
         dat_q <= cmd_wr ? cmd_data : 8'h00;
         chk_q <= frame_chk(cmd_wr ? CMD_WR : CMD_RD, cmd_addr[15:8],
                            cmd_addr[7:0], cmd_wr ? cmd_data : 8'h00);
      end
   end

   assign cmd_ack = ack_q;
   assign busy    = busy_q;
   assign tx_ctrl = tx_q;
   assign de_ctrl = de_q;

endmodule

// File: tb/tb_ctrl_tx.sv
// tb_ctrl_tx: directed bench for ctrl_tx. Instance a has one lead and one
// tail period, instance b has none; both run at four clocks per bit.
module tb_ctrl_tx;

   localparam int BD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
   logic [15:0] addr_a = '0, addr_b = '0;
   logic [7:0]  data_a = '0, data_b = '0;
   logic        ack_a, busy_a, tx_a, de_a;
   logic        ack_b, busy_b, tx_b, de_b;

   int n_vec  = 0;
   int n_miss = 0;
   int acks_a = 0;
   int acks_b = 0;

   ctrl_tx #(.BAUD_DIV(BD), .DE_LEAD(1), .DE_TAIL(1), .HDR(8'hA5)) u_dut_a (
      .clk_sys (clk),
      .rst     (rst),
      .cmd_req (req_a),
      .cmd_wr  (wr_a),
      .cmd_addr(addr_a),
      .cmd_data(data_a),
      .cmd_ack (ack_a),
      .busy    (busy_a),
      .tx_ctrl (tx_a),
      .de_ctrl (de_a)
   );

   ctrl_tx #(.BAUD_DIV(BD), .DE_LEAD(0), .DE_TAIL(0), .HDR(8'hA5)) u_dut_b (
      .clk_sys (clk),
      .rst     (rst),
      .cmd_req (req_b),
      .cmd_wr  (wr_b),
      .cmd_addr(addr_b),
      .cmd_data(data_b),
      .cmd_ack (ack_b),
      .busy    (busy_b),
      .tx_ctrl (tx_b),
      .de_ctrl (de_b)
   );

   always @(negedge clk) begin
      if (ack_a === 1'b1) acks_a++;
      if (ack_b === 1'b1) acks_b++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive a command on instance sel (0=a, 1=b) and wait for its ack; on
   // return we sit on the falling edge where the ack is first visible.
   task automatic req_cmd(input int sel, input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input bit hold);
      logic seen;
      seen = 1'b0;
      if (sel == 0) begin
         wr_a = wr; addr_a = a; data_a = d; req_a = 1'b1;
      end else begin
         wr_b = wr; addr_b = a; data_b = d; req_b = 1'b1;
      end
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = (sel == 0) ? (ack_a === 1'b1) : (ack_b === 1'b1);
      end
      check_val("ack_seen", {31'd0, seen}, 32'd1);
      if (!hold) begin
         if (sel == 0) req_a = 1'b0;
         else          req_b = 1'b0;
      end
   endtask

   // Sample each of the 60 bit periods mid-bit, rebuild the six bytes, then
   // measure how long busy stays high after the ack.
   task automatic check_frame(input int sel, input int lead, input int tail,
                              input logic [47:0] exp);
      int         x;
      int         ferr;
      int         target;
      int         pos;
      int         bi;
      logic       t;
      logic       de;
      logic [7:0] rx [6];
      x    = 0;
      ferr = 0;
      for (int i = 0; i < 6; i++) rx[i] = 8'h00;
      for (int k = 0; k < 60; k++) begin
         target = (lead + k) * BD + BD / 2;
         while (x < target) begin
            @(negedge clk);
            x++;
         end
         t   = (sel == 0) ? tx_a : tx_b;
         de  = (sel == 0) ? de_a : de_b;
         pos = k % 10;
         bi  = k / 10;
         if (pos == 0)      ferr += (t !== 1'b0) ? 1 : 0;
         else if (pos == 9) ferr += (t !== 1'b1) ? 1 : 0;
         else               rx[bi][pos-1] = t;
         if (de !== 1'b1) ferr++;
      end
      for (int i = 0; i < 6; i++)
         check_val($sformatf("byte%0d", i), {24'd0, rx[i]}, {24'd0, exp[47-8*i -: 8]});
      check_val("framing", ferr, 0);
      while (((sel == 0) ? busy_a : busy_b) === 1'b1 && x < 400) begin
         @(negedge clk);
         x++;
      end
      check_val("busy_len", x, (lead + 60 + tail) * BD);
      check_val("de_end", {31'd0, (sel == 0) ? de_a : de_b}, 32'd0);
      check_val("tx_end", {31'd0, (sel == 0) ? tx_a : tx_b}, 32'd1);
   endtask

   initial begin
      int a0;
      int b0;

      // Reset held three cycles with a request pulse during it.
      rst = 1'b1; req_a = 1'b1; wr_a = 1'b1; addr_a = 16'h1111; data_a = 8'h22;
      repeat (3) @(negedge clk);
      check_val("rst_tx", {31'd0, tx_a}, 32'd1);
      check_val("rst_de", {31'd0, de_a}, 32'd0);
      check_val("rst_busy", {31'd0, busy_a}, 32'd0);
      check_val("rst_ack", {31'd0, ack_a}, 32'd0);
      rst = 1'b0; req_a = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_no_ack", acks_a, 0);

      // Write 0x1234 <- 0x5A: checksum 01^12^34^5A = 7D.
      a0 = acks_a;
      req_cmd(0, 1'b1, 16'h1234, 8'h5A, 1'b0);
      check_frame(0, 1, 1, 48'hA5_01_12_34_5A_7D);
      repeat (4) @(negedge clk);
      check_val("wr_acks", acks_a - a0, 1);

      // Read 0x00FF with junk on the data input: 02^00^FF^00 = FD.
      a0 = acks_a;
      req_cmd(0, 1'b0, 16'h00FF, 8'hEE, 1'b0);
      check_frame(0, 1, 1, 48'hA5_02_00_FF_00_FD);
      repeat (4) @(negedge clk);
      check_val("rd_acks", acks_a - a0, 1);

      // Request held across two frames; inputs changed after the first ack.
      // Frame 1: 01^BE^EF^3C = 6C. Frame 2 (read 0x0A0B): 02^0A^0B^00 = 03.
      a0 = acks_a;
      req_cmd(0, 1'b1, 16'hBEEF, 8'h3C, 1'b1);
      wr_a = 1'b0; addr_a = 16'h0A0B; data_a = 8'h77;
      check_frame(0, 1, 1, 48'hA5_01_BE_EF_3C_6C);
      @(negedge clk);
      check_val("ack2_gap", {31'd0, ack_a}, 32'd1);
      req_a = 1'b0;
      check_frame(0, 1, 1, 48'hA5_02_0A_0B_00_03);
      repeat (4) @(negedge clk);
      check_val("hold_acks", acks_a - a0, 2);

      // Reset during byte B3 bit 4 (bit period 1+3*10+1+4 = 36).
      req_cmd(0, 1'b1, 16'h5555, 8'h66, 1'b0);
      repeat (36 * BD + BD / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("abort_tx", {31'd0, tx_a}, 32'd1);
      check_val("abort_de", {31'd0, de_a}, 32'd0);
      check_val("abort_busy", {31'd0, busy_a}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      // Recovery frame: 01^80^01^FF = 7F.
      req_cmd(0, 1'b1, 16'h8001, 8'hFF, 1'b0);
      check_frame(0, 1, 1, 48'hA5_01_80_01_FF_7F);

      // No lead/tail: start bit already on the line with the ack.
      // 01^A5^5A^81 = 7F.
      b0 = acks_b;
      req_cmd(1, 1'b1, 16'hA55A, 8'h81, 1'b0);
      check_val("start_on_ack", {31'd0, tx_b}, 32'd0);
      check_val("de_on_ack", {31'd0, de_b}, 32'd1);
      check_frame(1, 0, 0, 48'hA5_01_A5_5A_81_7F);
      repeat (4) @(negedge clk);
      check_val("b_acks", acks_b - b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
